// File: rtl/nibble_mac_mult_ctrl.sv
// rtl/nibble_mac_mult_ctrl.sv - sequential exact signed multiplier sharing one nibble multiplier (optional ZERO_BYPASS_EN)
module nibble_mac_mult_ctrl #(
  parameter int WIDTH = 16,
  parameter int NIB_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int NN  = WIDTH / NIB_W;
  localparam int CW  = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW  = 2 * WIDTH;
  localparam int PPW = 2 * NIB_W + 2;
  localparam int SHW = $clog2(PW) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [WIDTH-1:0]        a_r, b_r;
  logic [PW-1:0]           acc, acc_next, pp_ext;
  logic [CW-1:0]           i, j;
  logic [PW-1:0]           p_r;
  logic                    ov;
  logic [NIB_W-1:0]        a_nib [NN];
  logic [NIB_W-1:0]        b_nib [NN];
  logic [NIB_W-1:0]        na, nb;
  logic signed [NIB_W:0]   sa, sb;
  logic signed [PPW-1:0]   pp;
  logic [SHW-1:0]          sh;
  logic                    last_i, last_j;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = ov;
  assign p         = p_r;

  // Split the captured operands into nibbles for the operand mux
  always_comb begin
    for (int k = 0; k < NN; k++) begin
      a_nib[k] = a_r[k*NIB_W +: NIB_W];
      b_nib[k] = b_r[k*NIB_W +: NIB_W];
    end
  end

  // Single shared multiplier: select nibble pair (i, j), extend, multiply, align, accumulate
  always_comb begin
    last_i   = (i == CW'(NN - 1));
    last_j   = (j == CW'(NN - 1));
    na       = a_nib[i];
    nb       = b_nib[j];
    // Only the top nibble carries the operand sign; lower nibbles are magnitudes
    sa       = last_i ? {na[NIB_W-1], na} : {1'b0, na};
    sb       = last_j ? {nb[NIB_W-1], nb} : {1'b0, nb};
    pp       = PPW'(sa) * PPW'(sb);
    pp_ext   = {{(PW-PPW){pp[PPW-1]}}, pp};
    sh       = SHW'(NIB_W) * (SHW'(i) + SHW'(j));
    acc_next = acc + (pp_ext << sh);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      p_r   <= '0;
      ov    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            i   <= '0;
            j   <= '0;
`ifdef ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              p_r   <= '0;
              ov    <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
`else
            state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (last_j) begin
            j <= '0;
            i <= i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
          if (last_i && last_j) begin
            p_r   <= acc_next;
            ov    <= 1'b1;
            i     <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            ov    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
